int_sequencer: RTL and testbench

CPU-side responder for the Game Boy interrupt controller: samples the controller's active-low request at instruction boundaries and owns the master enable (IME). On acceptance it runs the M1+IORQ acknowledge cycle, latches the vector byte, and pushes the 16-bit PC to the stack with two bus writes. It then hands the CPU core a new PC/SP. Sits between the CPU core, the interrupt controller, and the memory bus arbiter.

---
 rtl/int_seq_pkg.sv | 20 ++
 rtl/int_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_int_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/int_seq_pkg.sv
// Shared types and reset constants for the CPU-side interrupt acknowledge sequencer.
package int_seq_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StAck    = 3'd1,
        StPushHi = 3'd2,
        StPushLo = 3'd3,
        StJump   = 3'd4
    } state_e;

    localparam logic [7:0]  VecHiDefault = 8'h00;

    localparam logic        StrobeRst    = 1'b1;
    localparam logic [15:0] BusARst      = 16'h0000;
    localparam logic [7:0]  BusDoRst     = 8'h00;
    localparam logic [15:0] PcNewRst     = 16'h0000;
    localparam logic [15:0] SpNewRst     = 16'h0000;

endpackage

// File: rtl/int_sequencer.sv
// Accepts interrupts at instruction boundaries, runs the M1+IORQ acknowledge, pushes PC to the
// stack and hands the CPU the vector PC and decremented SP. Also owns IME and its EI delay.
module int_sequencer
    import int_seq_pkg::*;
#(
    parameter int unsigned ACK_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        int_n,
    input  logic [7:0]  jump_addr,
    output logic        m1_n,
    output logic        iorq_n,
    input  logic        boundary,
    input  logic        ei,
    input  logic        di,
    input  logic        reti,
    input  logic [15:0] pc,
    input  logic [15:0] sp,
    output logic [15:0] bus_A,
    output logic [7:0]  bus_Do,
    output logic        bus_wr_n,
    input  logic        bus_ready,
    output logic        take,
    output logic        pc_load,
    output logic [15:0] pc_new,
    output logic [15:0] sp_new,
    output logic        ime
);

    localparam int unsigned CntW = $clog2(ACK_CYCLES + 1);
    localparam logic [CntW-1:0] AckLast = CntW'(ACK_CYCLES - 1);

    state_e         state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]    pc_l_q, pc_l_d;
    logic [15:0]    sp_l_q, sp_l_d;
    logic [7:0]     vec_q, vec_d;
    logic           ime_q, ime_d;
    logic           ime_pend_q, ime_pend_d;
    logic           m1_n_q, m1_n_d;
    logic           iorq_n_q, iorq_n_d;
    logic [15:0]    bus_a_q, bus_a_d;
    logic [7:0]     bus_do_q, bus_do_d;
    logic           bus_wr_n_q, bus_wr_n_d;
    logic           take_q, take_d;
    logic           pc_load_q, pc_load_d;
    logic [15:0]    pc_new_q, pc_new_d;
    logic [15:0]    sp_new_q, sp_new_d;
    logic           accept;

    assign accept = (state_q == StIdle) && boundary && ime_q && !int_n && !di;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_l_d     = pc_l_q;
        sp_l_d     = sp_l_q;
        vec_d      = vec_q;
        ime_d      = ime_q;
        ime_pend_d = ime_pend_q;
        m1_n_d     = m1_n_q;
        iorq_n_d   = iorq_n_q;
        bus_a_d    = bus_a_q;
        bus_do_d   = bus_do_q;
        bus_wr_n_d = bus_wr_n_q;
        take_d     = take_q;
        pc_load_d  = pc_load_q;
        pc_new_d   = pc_new_q;
        sp_new_d   = sp_new_q;

        // Promotion precedes a same-cycle EI so that EI still arms the next boundary.
        if (di) begin
            ime_d      = 1'b0;
            ime_pend_d = 1'b0;
        end else begin
            if ((state_q == StIdle) && boundary && ime_pend_q) begin
                ime_d      = 1'b1;
                ime_pend_d = 1'b0;
            end
            if (ei) begin
                ime_pend_d = 1'b1;
            end
            if (reti) begin
                ime_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    pc_l_d   = pc;
                    sp_l_d   = sp;
                    ime_d    = 1'b0;
                    take_d   = 1'b1;
                    m1_n_d   = 1'b0;
                    iorq_n_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = StAck;
                end
            end
            StAck: begin
                if (cnt_q == AckLast) begin
                    m1_n_d     = 1'b1;
                    iorq_n_d   = 1'b1;
                    vec_d      = jump_addr;
                    bus_a_d    = sp_l_q - 16'd1;
                    bus_do_d   = pc_l_q[15:8];
                    bus_wr_n_d = 1'b0;
                    state_d    = StPushHi;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPushHi: begin
                if (bus_ready) begin
                    bus_a_d  = sp_l_q - 16'd2;
                    bus_do_d = pc_l_q[7:0];
                    state_d  = StPushLo;
                end
            end
            StPushLo: begin
                if (bus_ready) begin
                    bus_wr_n_d = 1'b1;
                    pc_load_d  = 1'b1;
                    pc_new_d   = {VecHiDefault, vec_q};
                    sp_new_d   = sp_l_q - 16'd2;
                    state_d    = StJump;
                end
            end
            StJump: begin
                pc_load_d = 1'b0;
                take_d    = 1'b0;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            pc_l_q     <= 16'h0000;
            sp_l_q     <= 16'h0000;
            vec_q      <= 8'h00;
            ime_q      <= 1'b0;
            ime_pend_q <= 1'b0;
            m1_n_q     <= StrobeRst;
            iorq_n_q   <= StrobeRst;
            bus_a_q    <= BusARst;
            bus_do_q   <= BusDoRst;
            bus_wr_n_q <= StrobeRst;
            take_q     <= 1'b0;
            pc_load_q  <= 1'b0;
            pc_new_q   <= PcNewRst;
            sp_new_q   <= SpNewRst;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_l_q     <= pc_l_d;
            sp_l_q     <= sp_l_d;
            vec_q      <= vec_d;
            ime_q      <= ime_d;
            ime_pend_q <= ime_pend_d;
            m1_n_q     <= m1_n_d;
            iorq_n_q   <= iorq_n_d;
            bus_a_q    <= bus_a_d;
            bus_do_q   <= bus_do_d;
            bus_wr_n_q <= bus_wr_n_d;
            take_q     <= take_d;
            pc_load_q  <= pc_load_d;
            pc_new_q   <= pc_new_d;
            sp_new_q   <= sp_new_d;
        end
    end

    assign m1_n     = m1_n_q;
    assign iorq_n   = iorq_n_q;
    assign bus_A    = bus_a_q;
    assign bus_Do   = bus_do_q;
    assign bus_wr_n = bus_wr_n_q;
    assign take     = take_q;
    assign pc_load  = pc_load_q;
    assign pc_new   = pc_new_q;
    assign sp_new   = sp_new_q;
    assign ime      = ime_q;

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer: stack writes and PC/SP handoff are scored against queues.
module tb_int_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        int_n = 1'b1;
    logic [7:0]  jump_addr = 8'h00;
    logic        m1_n, iorq_n;
    logic        boundary = 1'b0;
    logic        ei = 1'b0, di = 1'b0, reti = 1'b0;
    logic [15:0] pc = 16'h0000, sp = 16'h0000;
    logic [15:0] bus_A;
    logic [7:0]  bus_Do;
    logic        bus_wr_n;
    logic        bus_ready = 1'b1;
    logic        take, pc_load, ime;
    logic [15:0] pc_new, sp_new;

    int errors = 0;
    int checks = 0;

    logic [23:0] wr_q[$];
    logic [31:0] jmp_q[$];

    int_sequencer #(.ACK_CYCLES(2)) dut (
        .clock(clock), .reset_n(reset_n), .int_n(int_n), .jump_addr(jump_addr),
        .m1_n(m1_n), .iorq_n(iorq_n), .boundary(boundary), .ei(ei), .di(di), .reti(reti),
        .pc(pc), .sp(sp), .bus_A(bus_A), .bus_Do(bus_Do), .bus_wr_n(bus_wr_n),
        .bus_ready(bus_ready), .take(take), .pc_load(pc_load), .pc_new(pc_new),
        .sp_new(sp_new), .ime(ime)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Accept edge happens inside this task; on return the bench sits in cycle 1.
    task automatic start(input logic [15:0] p, input logic [15:0] s, input logic [7:0] v);
        logic [15:0] s1, s2;
        s1 = s - 16'd1;
        s2 = s - 16'd2;
        wr_q.push_back({s1, p[15:8]});
        wr_q.push_back({s2, p[7:0]});
        jmp_q.push_back({8'h00, v, s2});
        pc = p;
        sp = s;
        jump_addr = v;
        int_n = 1'b0;
        boundary = 1'b1;
        tick();
        boundary = 1'b0;
    endtask

    task automatic set_ime();
        reti = 1'b1;
        tick();
        reti = 1'b0;
        check("ime_set_by_reti", ime, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (take && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_done"}, take, 0);
        check({tag, "_wr_drained"}, wr_q.size(), 0);
        check({tag, "_jmp_drained"}, jmp_q.size(), 0);
    endtask

    // Scoreboard: every accepted write and every pc_load pops one expectation.
    always @(negedge clock) begin
        if (reset_n) begin
            if (!bus_wr_n && bus_ready) begin
                checks++;
                assert (wr_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_write: observed %0h<-%0h expected none",
                           bus_A, bus_Do);
                end
                if (wr_q.size() != 0) check("stack_write", {bus_A, bus_Do}, wr_q.pop_front());
            end
            if (pc_load) begin
                checks++;
                assert (jmp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_pc_load: observed %0h/%0h expected none",
                           pc_new, sp_new);
                end
                if (jmp_q.size() != 0) check("pc_sp_new", {pc_new, sp_new}, jmp_q.pop_front());
            end
        end
    end

    initial begin
        // Reset state
        tick();
        check("rst_m1_n", m1_n, 1);
        check("rst_iorq_n", iorq_n, 1);
        check("rst_wr_n", bus_wr_n, 1);
        check("rst_bus", {bus_A, bus_Do}, 0);
        check("rst_take_load", {take, pc_load}, 0);
        check("rst_pc_sp_new", {pc_new, sp_new}, 0);
        check("rst_ime", ime, 0);
        reset_n = 1'b1;
        tick();

        // Basic sequence with exact cycle timing
        set_ime();
        start(16'h1234, 16'hFFFE, 8'hA4);
        check("t1_c1_ack", {m1_n, iorq_n, take}, 3'b001);
        check("t1_c1_ime", ime, 0);
        tick();
        int_n = 1'b1;
        check("t1_c2_ack", {m1_n, iorq_n}, 2'b00);
        tick();
        check("t1_c3_strobes_up", {m1_n, iorq_n}, 2'b11);
        check("t1_c3_push_hi", {bus_wr_n, bus_A, bus_Do}, {1'b0, 16'hFFFD, 8'h12});
        tick();
        check("t1_c4_push_lo", {bus_wr_n, bus_A, bus_Do}, {1'b0, 16'hFFFC, 8'h34});
        tick();
        check("t1_c5_pc_load", {pc_load, bus_wr_n, take}, 3'b111);
        check("t1_c5_vals", {pc_new, sp_new}, {16'h00A4, 16'hFFFC});
        tick();
        check("t1_c6_idle", {take, pc_load}, 2'b00);
        check("t1_ime", ime, 0);
        wait_idle("t1");

        // EI delays enable by one boundary
        ei = 1'b1;
        tick();
        ei = 1'b0;
        check("t2_ime_not_yet", ime, 0);
        pc = 16'h5678;
        sp = 16'hC000;
        int_n = 1'b0;
        boundary = 1'b1;
        tick();
        boundary = 1'b0;
        check("t2_no_accept", take, 0);
        check("t2_ime_promoted", ime, 1);
        tick();
        start(16'h5678, 16'hC000, 8'h48);
        check("t2_accept", take, 1);
        int_n = 1'b1;
        wait_idle("t2");

        // DI blocks same-cycle accept; EI+DI leaves nothing pending
        set_ime();
        di = 1'b1;
        boundary = 1'b1;
        int_n = 1'b0;
        tick();
        di = 1'b0;
        boundary = 1'b0;
        check("t3_di_no_accept", take, 0);
        check("t3_di_ime", ime, 0);
        ei = 1'b1;
        di = 1'b1;
        tick();
        ei = 1'b0;
        di = 1'b0;
        boundary = 1'b1;
        tick();
        tick();
        boundary = 1'b0;
        check("t3_ei_di_ime", ime, 0);
        check("t3_ei_di_take", take, 0);
        int_n = 1'b1;
        tick();

        // SP wraparound
        set_ime();
        start(16'hBEEF, 16'h0001, 8'h50);
        int_n = 1'b1;
        wait_idle("t4");

        // bus_ready stall in PUSH_HI
        set_ime();
        start(16'hA55A, 16'h8000, 8'h60);
        int_n = 1'b1;
        tick();
        tick();
        bus_ready = 1'b0;
        check("t5_push_hi", {bus_wr_n, bus_A, bus_Do}, {1'b0, 16'h7FFF, 8'hA5});
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_stall_stable", {bus_wr_n, bus_A, bus_Do}, {1'b0, 16'h7FFF, 8'hA5});
            check("t5_stall_no_load", pc_load, 0);
        end
        bus_ready = 1'b1;
        tick();
        check("t5_push_lo", {bus_wr_n, bus_A, bus_Do}, {1'b0, 16'h7FFE, 8'h5A});
        tick();
        check("t5_pc_load_c8", pc_load, 1);
        wait_idle("t5");

        // Reset during PUSH_LO
        set_ime();
        start(16'h1357, 16'h4000, 8'h70);
        int_n = 1'b1;
        tick();
        tick();
        tick();
        check("t6_in_push_lo", {bus_wr_n, bus_A, bus_Do}, {1'b0, 16'h3FFE, 8'h57});
        #2;
        reset_n = 1'b0;
        wr_q.delete();
        jmp_q.delete();
        #1;
        check("t6_rst_strobes", {m1_n, iorq_n, bus_wr_n}, 3'b111);
        check("t6_rst_bus", {bus_A, bus_Do}, 0);
        check("t6_rst_ctl", {take, pc_load, ime}, 0);
        check("t6_rst_pc_sp_new", {pc_new, sp_new}, 0);
        tick();
        tick();
        reset_n = 1'b1;
        int_n = 1'b0;
        boundary = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_post_rst_quiet", {take, ime, bus_wr_n}, 3'b001);
        end
        boundary = 1'b0;
        int_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
